rgb_de_capture: RTL

DE-mode RGB565 receiver for the LCD pixel path: samples `lcd_de`/`lcd_rgb` on the pixel clock, recovers line and frame boundaries from DE alone (HS/VS are held high on this panel interface), and emits per-pixel coordinates and data. It also checks the line and frame geometry. It sits on the far side of the LCD timing generator, either as a loopback checker in the test build or feeding a frame-capture/compare path.

---
 rtl/rgb_pkg.sv | 44 ++++
 rtl/rgb_crc16.sv | 32 +++
 rtl/rgb_de_capture.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// rgb_pkg: shared constants, state encoding and CRC helper for the DE-mode
// RGB565 capture path.
package rgb_pkg;

   // Default display geometry (525 x 286 total, 480 x 272 active)
   localparam int LCD_H_DISP    = 480;
   localparam int LCD_V_DISP    = 272;
   localparam int LCD_H_TOTAL   = 525;
   localparam int LCD_V_TOTAL   = 286;
   // Idle run that separates vertical blanking from horizontal blanking
   localparam int LCD_FRAME_GAP = 1050;

   localparam int XY_W   = 11;
   localparam int IDLE_W = 12;

   // CRC-16/CCITT parameters
   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VBLANK = 2'd1,
      LINE   = 2'd2,
      HBLANK = 2'd3
   } cap_state_e;

   // Increment that sticks at the all-ones value
   function automatic logic [XY_W-1:0] sat_inc(input logic [XY_W-1:0] v);
      return (v == {XY_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   // One CRC-16/CCITT step over a 16-bit word, MSB first
   function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                              input logic [15:0] data);
      logic [15:0] c;
      c = crc_in;
      for (int i = 15; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/rgb_crc16.sv
// rgb_crc16: running CRC-16/CCITT, one 16-bit word per clock.
// init restarts from CRC_INIT; if en is also high the word is folded in
// on top of the fresh seed so the first word of a frame is included.
import rgb_pkg::*;

module rgb_crc16 (
   input  logic        lcd_clk_w,
   input  logic        rst_n_w,
   input  logic        init,
   input  logic        en,
   input  logic [15:0] data,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;

   // Next CRC value: seed on init, fold data when enabled
   always_comb begin
      crc_d = crc_q;
      if (en)        crc_d = crc16_step(init ? CRC_INIT : crc_q, data);
      else if (init) crc_d = CRC_INIT;
   end

   // CRC accumulator register
   always_ff @(posedge lcd_clk_w or negedge rst_n_w) begin
      if (!rst_n_w) crc_q <= '0;
      else          crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/rgb_de_capture.sv
// rgb_de_capture: DE-mode RGB565 receiver. Recovers line and frame
// boundaries from lcd_de alone, emits per-pixel coordinates and data, and
// flags line-length / line-count errors.
// Optional feature macro: RGB_CAP_CRC_EN adds the frame_crc output.
import rgb_pkg::*;

module rgb_de_capture #(
   parameter int H_DISP    = LCD_H_DISP,
   parameter int V_DISP    = LCD_V_DISP,
   parameter int FRAME_GAP = LCD_FRAME_GAP
) (
   input  logic        lcd_clk_w,
   input  logic        rst_n_w,
   input  logic        lcd_de,
   input  logic [15:0] lcd_rgb,
   output logic        pix_valid,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic [15:0] pix_data,
   output logic        frame_start,
   output logic        frame_done,
   output logic        line_len_err,
   output logic        frame_len_err,
   output logic        sync_ok,
   output logic [15:0] frame_cnt
`ifdef RGB_CAP_CRC_EN
   ,
   output logic [15:0] frame_crc
`endif
);

   localparam logic [XY_W-1:0]   H_DISP_C = XY_W'(H_DISP);
   localparam logic [XY_W-1:0]   H_LAST   = XY_W'(H_DISP - 1);
   localparam logic [XY_W-1:0]   V_DISP_C = XY_W'(V_DISP);
   localparam logic [XY_W-1:0]   V_LAST   = XY_W'(V_DISP - 1);
   localparam logic [IDLE_W-1:0] GAP_C    = IDLE_W'(FRAME_GAP);

   // Input stage; de_q_d is the previous de_q, used for edge detection
   logic              de_q, de_q_d;
   logic [15:0]       rgb_q;

   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   cap_state_e        state_q, state_d;
   logic [XY_W-1:0]   x_q, x_d, y_q, y_d;

   logic              pix_valid_q, pix_valid_d;
   logic [XY_W-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [15:0]       pix_data_q, pix_data_d;
   logic              frame_start_q, frame_start_d;
   logic              frame_done_q, frame_done_d;
   logic              line_len_err_q, line_len_err_d;
   logic              frame_len_err_q, frame_len_err_d;
   logic              sync_ok_q, sync_ok_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;

   logic              de_rise, gap_hit, emit;
   logic [XY_W-1:0]   emit_x, emit_y;

   // Register the raw panel inputs and keep one cycle of DE history
   always_ff @(posedge lcd_clk_w or negedge rst_n_w) begin
      if (!rst_n_w) begin
         de_q   <= 1'b0;
         de_q_d <= 1'b0;
         rgb_q  <= '0;
      end else begin
         de_q   <= lcd_de;
         de_q_d <= de_q;
         rgb_q  <= lcd_rgb;
      end
   end

   // DE rise detect and saturating DE-low run counter
   always_comb begin
      de_rise = de_q & ~de_q_d;
      gap_hit = (idle_cnt_q == GAP_C);
      if (de_q)                    idle_cnt_d = '0;
      else if (idle_cnt_q < GAP_C) idle_cnt_d = idle_cnt_q + 1'b1;
      else                         idle_cnt_d = idle_cnt_q;
   end

   // Framing FSM: next state, pixel position and event strobes
   always_comb begin
      state_d         = state_q;
      x_d             = x_q;
      y_d             = y_q;
      emit            = 1'b0;
      emit_x          = x_q;
      emit_y          = y_q;
      frame_start_d   = 1'b0;
      frame_done_d    = 1'b0;
      line_len_err_d  = 1'b0;
      frame_len_err_d = 1'b0;
      sync_ok_d       = sync_ok_q;
      frame_cnt_d     = frame_cnt_q;
      case (state_q)
         HUNT: begin
            // Pixels are ignored until a full vertical gap proves alignment
            if (gap_hit) begin
               state_d   = VBLANK;
               sync_ok_d = 1'b1;
            end
         end
         VBLANK: begin
            if (de_rise) begin
               state_d       = LINE;
               emit          = 1'b1;
               emit_x        = '0;
               emit_y        = '0;
               frame_start_d = 1'b1;
               x_d           = XY_W'(1);
               y_d           = '0;
            end
         end
         LINE: begin
            if (de_q) begin
               emit = 1'b1;
               x_d  = sat_inc(x_q);
            end else begin
               // DE fell: x now holds the run length of the finished line
               state_d        = HBLANK;
               line_len_err_d = (x_q != H_DISP_C);
               y_d            = sat_inc(y_q);
            end
         end
         HBLANK: begin
            if (de_rise) begin
               state_d = LINE;
               emit    = 1'b1;
               emit_x  = '0;
               x_d     = XY_W'(1);
            end else if (gap_hit) begin
               state_d         = VBLANK;
               frame_done_d    = 1'b1;
               frame_len_err_d = (y_q != V_DISP_C);
               frame_cnt_d     = frame_cnt_q + 16'd1;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // Output staging: clamp coordinates, hold last pixel between strobes
   always_comb begin
      pix_valid_d = emit;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      pix_data_d  = pix_data_q;
      if (emit) begin
         pix_x_d    = (emit_x >= H_DISP_C) ? H_LAST : emit_x;
         pix_y_d    = (emit_y >= V_DISP_C) ? V_LAST : emit_y;
         pix_data_d = rgb_q;
      end
   end

   // State, position and output registers
   always_ff @(posedge lcd_clk_w or negedge rst_n_w) begin
      if (!rst_n_w) begin
         state_q         <= HUNT;
         idle_cnt_q      <= '0;
         x_q             <= '0;
         y_q             <= '0;
         pix_valid_q     <= 1'b0;
         pix_x_q         <= '0;
         pix_y_q         <= '0;
         pix_data_q      <= '0;
         frame_start_q   <= 1'b0;
         frame_done_q    <= 1'b0;
         line_len_err_q  <= 1'b0;
         frame_len_err_q <= 1'b0;
         sync_ok_q       <= 1'b0;
         frame_cnt_q     <= '0;
      end else begin
         state_q         <= state_d;
         idle_cnt_q      <= idle_cnt_d;
         x_q             <= x_d;
         y_q             <= y_d;
         pix_valid_q     <= pix_valid_d;
         pix_x_q         <= pix_x_d;
         pix_y_q         <= pix_y_d;
         pix_data_q      <= pix_data_d;
         frame_start_q   <= frame_start_d;
         frame_done_q    <= frame_done_d;
         line_len_err_q  <= line_len_err_d;
         frame_len_err_q <= frame_len_err_d;
         sync_ok_q       <= sync_ok_d;
         frame_cnt_q     <= frame_cnt_d;
      end
   end

   assign pix_valid     = pix_valid_q;
   assign pix_x         = pix_x_q;
   assign pix_y         = pix_y_q;
   assign pix_data      = pix_data_q;
   assign frame_start   = frame_start_q;
   assign frame_done    = frame_done_q;
   assign line_len_err  = line_len_err_q;
   assign frame_len_err = frame_len_err_q;
   assign sync_ok       = sync_ok_q;
   assign frame_cnt     = frame_cnt_q;

`ifdef RGB_CAP_CRC_EN
   logic [15:0] crc_run;
   logic [15:0] frame_crc_q, frame_crc_d;

   rgb_crc16 u_crc (
      .lcd_clk_w (lcd_clk_w),
      .rst_n_w   (rst_n_w),
      .init      (frame_start_d),
      .en        (emit),
      .data      (rgb_q),
      .crc       (crc_run)
   );

   // Latch the frame CRC alongside frame_done
   always_comb begin
      frame_crc_d = frame_done_d ? crc_run : frame_crc_q;
   end

   // Frame CRC output register
   always_ff @(posedge lcd_clk_w or negedge rst_n_w) begin
      if (!rst_n_w) frame_crc_q <= '0;
      else          frame_crc_q <= frame_crc_d;
   end

   assign frame_crc = frame_crc_q;
`endif

endmodule
